// File: rtl/huffman_decoder.sv
// Huffman decoder: unpacks LSB-first 32-bit code words into a 64-bit bit
// buffer and decodes one prefix-free code per cycle against a runtime-loaded
// table, presenting 8-bit symbols on a valid/ready port.
module huffman_decoder #(
    parameter int TBL_ENTRIES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] encoded_in,
    input  logic        enable_in,
    output logic        in_ready,
    input  logic        tbl_we,
    input  logic [3:0]  tbl_addr,
    input  logic [7:0]  tbl_code,
    input  logic [3:0]  tbl_len,
    input  logic [7:0]  tbl_sym,
    output logic [7:0]  symbol_out,
    output logic        symbol_valid,
    input  logic        symbol_ready,
    output logic        error
);

    // Bit buffer: oldest bit at bit 0, count_reg valid bits (0..64).
    logic [63:0] bit_buf_reg;
    logic [63:0] bit_buf_next;
    logic [6:0]  count_reg;
    logic [6:0]  count_next;

    // Output register and sticky error.
    logic [7:0]  sym_reg;
    logic        valid_reg;
    logic        error_reg;
    logic        error_next;

    // Table contents as seen by the match logic.
    logic [7:0]  tbl_code_arr [TBL_ENTRIES];
    logic [3:0]  tbl_len_arr  [TBL_ENTRIES];
    logic [7:0]  tbl_sym_arr  [TBL_ENTRIES];
    logic [TBL_ENTRIES-1:0] match_vec;

    // Selected (lowest-index) match.
    logic        hit;
    logic [3:0]  hit_len;
    logic [7:0]  hit_sym;

    // Per-cycle control.
    logic        fire;
    logic        accept;
    logic [6:0]  consume;
    logic [6:0]  count_after;

    genvar gi;
    generate
        for (gi = 0; gi < TBL_ENTRIES; gi++) begin : g_entry
            logic [7:0] code_reg;
            logic [3:0] len_reg;
            logic [7:0] sym_entry_reg;
            logic [7:0] mask;

            // Table entry storage; reset only empties the entry via its length.
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    len_reg <= 4'd0;
                end else if (tbl_we && (tbl_addr == 4'(gi))) begin
                    code_reg      <= tbl_code;
                    len_reg       <= tbl_len;
                    sym_entry_reg <= tbl_sym;
                end
            end

            assign tbl_code_arr[gi] = code_reg;
            assign tbl_len_arr[gi]  = len_reg;
            assign tbl_sym_arr[gi]  = sym_entry_reg;

            // Low L bits set; only meaningful for L in 1..8.
            assign mask = ~(8'hFF << len_reg);
            assign match_vec[gi] = (len_reg != 4'd0) && (len_reg <= 4'd8) &&
                                   ({3'd0, len_reg} <= count_reg) &&
                                   (((bit_buf_reg[7:0] ^ code_reg) & mask) == 8'h00);
        end
    endgenerate

    // Priority select: scanning downward leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_len = 4'd0;
        hit_sym = 8'h00;
        for (int i = TBL_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit     = 1'b1;
                hit_len = tbl_len_arr[i];
                hit_sym = tbl_sym_arr[i];
            end
        end
    end

    assign in_ready = (count_reg <= 7'd32) && !error_reg;
    assign fire     = hit && !error_reg && (!valid_reg || symbol_ready);
    assign accept   = enable_in && in_ready;

    // Buffer update: drop consumed bits, append an accepted word behind the rest.
    always_comb begin
        consume      = fire ? {3'd0, hit_len} : 7'd0;
        count_after  = count_reg - consume;
        bit_buf_next = bit_buf_reg >> consume;
        if (accept) begin
            bit_buf_next = bit_buf_next | ({32'd0, encoded_in} << count_after);
        end
        count_next = count_after + (accept ? 7'd32 : 7'd0);
        error_next = error_reg || ((count_reg >= 7'd8) && !hit);
    end

    // Buffer, output register and error state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            bit_buf_reg <= 64'd0;
            count_reg   <= 7'd0;
            sym_reg     <= 8'h00;
            valid_reg   <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            bit_buf_reg <= bit_buf_next;
            count_reg   <= count_next;
            error_reg   <= error_next;
            if (fire) begin
                sym_reg   <= hit_sym;
                valid_reg <= 1'b1;
            end else if (symbol_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign symbol_out   = sym_reg;
    assign symbol_valid = valid_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with a bit-queue decoding model.
module tb_huffman_decoder;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] encoded_in;
    logic        enable_in;
    logic        in_ready;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [7:0]  tbl_code;
    logic [3:0]  tbl_len;
    logic [7:0]  tbl_sym;
    logic [7:0]  symbol_out;
    logic        symbol_valid;
    logic        symbol_ready;
    logic        error;

    huffman_decoder #(.TBL_ENTRIES(16)) dut (
        .clock(clock), .resetn(resetn),
        .encoded_in(encoded_in), .enable_in(enable_in), .in_ready(in_ready),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code),
        .tbl_len(tbl_len), .tbl_sym(tbl_sym),
        .symbol_out(symbol_out), .symbol_valid(symbol_valid),
        .symbol_ready(symbol_ready), .error(error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    bit mon_en   = 0;

    // Model: stream bits oldest-first, expected symbols, table, error.
    bit       mbits [$];
    bit [7:0] exp_q [$];
    bit [7:0] mtbl_code [16];
    int       mtbl_len  [16];
    bit [7:0] mtbl_sym  [16];
    bit       merr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Decode as many whole codes as the queued bits allow.
    task automatic model_decode();
        bit found;
        bit ok;
        int len;
        while (!merr) begin
            found = 0;
            for (int i = 0; i < 16 && !found; i++) begin
                len = mtbl_len[i];
                if (len >= 1 && len <= 8 && len <= mbits.size()) begin
                    ok = 1;
                    for (int b = 0; b < len; b++)
                        if (mbits[b] != mtbl_code[i][b]) ok = 0;
                    if (ok) begin
                        found = 1;
                        for (int b = 0; b < len; b++) void'(mbits.pop_front());
                        exp_q.push_back(mtbl_sym[i]);
                    end
                end
            end
            if (!found) begin
                if (mbits.size() >= 8) merr = 1;
                break;
            end
        end
    endtask

    task automatic model_flush();
        mbits.delete();
        exp_q.delete();
        merr = 0;
        for (int i = 0; i < 16; i++) mtbl_len[i] = 0;
    endtask

    // Compare process: symbol against model head whenever valid, pop on handshake.
    always @(negedge clock) begin
        if (mon_en && resetn) begin
            if (!merr) check("no_error", {31'd0, error}, 32'd0);
            if (symbol_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got symbol 0x%0h expected none at %0t", symbol_out, $time);
                end else begin
                    check("symbol", {24'd0, symbol_out}, {24'd0, exp_q[0]});
                    if (symbol_ready) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                    end
                end
            end
        end
    end

    // All tasks below start and end at posedge + 1.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_flush();
    endtask

    task automatic tbl_load(input int addr, input logic [7:0] code, input logic [3:0] len, input logic [7:0] sym);
        tbl_we   = 1'b1;
        tbl_addr = 4'(addr);
        tbl_code = code;
        tbl_len  = len;
        tbl_sym  = sym;
        step();
        tbl_we = 1'b0;
        mtbl_code[addr] = code;
        mtbl_len[addr]  = int'(len);
        mtbl_sym[addr]  = sym;
    endtask

    task automatic load_basic();
        tbl_load(0, 8'h00, 4'd1, 8'h41);
        tbl_load(1, 8'h01, 4'd2, 8'h42);
        tbl_load(2, 8'h03, 4'd2, 8'h43);
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            encoded_in = w;
            enable_in  = 1'b1;
            step();
            enable_in = 1'b0;
            for (int b = 0; b < 32; b++) mbits.push_back(w[b]);
            model_decode();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || symbol_valid) && t < 400) begin
            step();
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; encoded_in = 32'd0; enable_in = 1'b0;
        tbl_we = 1'b0; tbl_addr = 4'd0; tbl_code = 8'd0; tbl_len = 4'd0; tbl_sym = 8'd0;
        symbol_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin mtbl_code[i] = 0; mtbl_sym[i] = 0; end
        step();
        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, symbol_valid}, 32'd0);
        check("rst_symbol", {24'd0, symbol_out}, 32'h00);
        check("rst_error", {31'd0, error}, 32'd0);
        mon_en = 1;

        // Basic decode, latency and throughput.
        load_basic();
        send_word(32'h0000001A);
        check("model_count", exp_q.size(), 32'd30);
        check("model_s0", {24'd0, exp_q[0]}, 32'h41);
        check("model_s1", {24'd0, exp_q[1]}, 32'h42);
        check("model_s2", {24'd0, exp_q[2]}, 32'h43);
        check("model_s3", {24'd0, exp_q[3]}, 32'h41);
        check("latency_pre", {31'd0, symbol_valid}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            step();
            check("thru_valid", {31'd0, symbol_valid}, 32'd1);
            if (i == 0) check("first_symbol", {24'd0, symbol_out}, 32'h41);
        end
        step();
        check("thru_done", {31'd0, symbol_valid}, 32'd0);
        check("basic_count", {25'd0, dut.count_reg}, 32'd0);

        // Backpressure.
        n_hs = 0;
        symbol_ready = 1'b0;
        send_word(32'h0000001A);
        send_word(32'h0000001A);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold", {23'd0, symbol_valid, symbol_out}, 32'h141);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        symbol_ready = 1'b1;
        send_word(32'h0000001A);
        drain();
        check("bp_total", n_hs, 32'd90);

        // Cross-word 8-bit codes.
        do_reset();
        tbl_load(0, 8'h00, 4'd1, 8'h41);
        tbl_load(3, 8'hA5, 4'd8, 8'h55);
        symbol_ready = 1'b0;
        send_word(32'hA5000000);
        send_word(32'h000000A5);
        check("xw_model_count", exp_q.size(), 32'd50);
        check("xw_model_23", {24'd0, exp_q[23]}, 32'h41);
        check("xw_model_24", {24'd0, exp_q[24]}, 32'h55);
        check("xw_model_25", {24'd0, exp_q[25]}, 32'h55);
        symbol_ready = 1'b1;
        drain();
        check("xw_error", {31'd0, error}, 32'd0);
        check("xw_count", {25'd0, dut.count_reg}, 32'd0);

        // Error on unmatched bits.
        do_reset();
        tbl_load(1, 8'h01, 4'd2, 8'h42);
        tbl_load(2, 8'h03, 4'd2, 8'h43);
        send_word(32'h00000000);
        check("err_model", {31'd0, merr}, 32'd1);
        check("err_not_yet", {31'd0, error}, 32'd0);
        step();
        check("err_set", {31'd0, error}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("err_in_ready", {31'd0, in_ready}, 32'd0);
            check("err_no_valid", {31'd0, symbol_valid}, 32'd0);
            step();
        end
        do_reset();
        check("err_cleared", {31'd0, error}, 32'd0);
        check("err_in_ready_back", {31'd0, in_ready}, 32'd1);

        // Reset mid-stream with a word presented.
        load_basic();
        send_word(32'h0000001A);
        for (int i = 0; i < 5; i++) step();
        check("mid_pre_valid", {31'd0, symbol_valid}, 32'd1);
        encoded_in   = 32'hDEADBEEF;
        enable_in    = 1'b1;
        symbol_ready = 1'b0;
        do_reset();
        enable_in    = 1'b0;
        symbol_ready = 1'b1;
        check("mid_valid", {31'd0, symbol_valid}, 32'd0);
        check("mid_symbol", {24'd0, symbol_out}, 32'h00);
        check("mid_count", {25'd0, dut.count_reg}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'h0000001A);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_symbol", {31'd0, symbol_valid}, 32'd0);
        end
        check("mid_empty_error", {31'd0, error}, 32'd1);
        do_reset();

        // Simultaneous accept and consume at count 31.
        load_basic();
        symbol_ready = 1'b0;
        send_word(32'hF0F0F0F2);
        step();
        check("sim_count31", {25'd0, dut.count_reg}, 32'd31);
        check("sim_head_sym", {23'd0, symbol_valid, symbol_out}, 32'h141);
        symbol_ready = 1'b1;
        send_word(32'h000000F3);
        check("sim_count61", {25'd0, dut.count_reg}, 32'd61);
        check("sim_in_ready", {31'd0, in_ready}, 32'd0);
        drain();
        check("sim_count_end", {25'd0, dut.count_reg}, 32'd0);

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
